// File: rtl/non_res_div_param.sv
// Sequential non-restoring divider: 2W/W -> W quotient + W remainder over a W-bit bus.
// Define NON_RES_DIV_SIGNED_EN for two's-complement operands.
module non_res_div_param #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         begin_div,
  input  logic [W-1:0] in_bus,
  output logic [W-1:0] out_bus,
  output logic         fin,
  output logic         busy,
  output logic         dbz,
  output logic         ovf
);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] LOAD_HI  = 4'd1;
  localparam logic [3:0] LOAD_LO  = 4'd2;
  localparam logic [3:0] LOAD_DIV = 4'd3;
  localparam logic [3:0] CHECK    = 4'd4;
  localparam logic [3:0] ITER     = 4'd5;
  localparam logic [3:0] CORR     = 4'd6;
  localparam logic [3:0] OUT_Q    = 4'd7;
  localparam logic [3:0] OUT_R    = 4'd8;
  localparam int CW = $clog2(W);

  logic [3:0]     state;
  logic [W-1:0]   hi_r, lo_r, dv_r, q_r, r_r;
  logic [W:0]     rem_r;
  logic [CW-1:0]  cnt;
  logic           err;

  logic [2*W-1:0] dd_mag;
  logic [W-1:0]   dv_mag;
  logic           is_ovf;

`ifdef NON_RES_DIV_SIGNED_EN
  logic           sd_r, sv_r;
  logic [2*W-1:0] ovf_lim;
  assign dd_mag  = hi_r[W-1] ? -{hi_r, lo_r} : {hi_r, lo_r};
  assign dv_mag  = dv_r[W-1] ? -dv_r : dv_r;
  // quotient magnitude must stay below 2^(W-1)
  assign ovf_lim = {{W{1'b0}}, dv_mag} << (W-1);
  assign is_ovf  = dd_mag >= ovf_lim;
`else
  assign dd_mag  = {hi_r, lo_r};
  assign dv_mag  = dv_r;
  assign is_ovf  = hi_r >= dv_r;
`endif

  // One non-restoring step; wrap in W+1 bits is safe since the result lies in [-d, d).
  logic [W:0] sh, nrem, rfin;
  assign sh   = {rem_r[W-1:0], lo_r[W-1]};
  assign nrem = rem_r[W] ? sh + {1'b0, dv_r} : sh - {1'b0, dv_r};
  assign rfin = rem_r[W] ? rem_r + {1'b0, dv_r} : rem_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hi_r  <= '0;
      lo_r  <= '0;
      dv_r  <= '0;
      q_r   <= '0;
      r_r   <= '0;
      rem_r <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
`ifdef NON_RES_DIV_SIGNED_EN
      sd_r  <= 1'b0;
      sv_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (begin_div) begin
          dbz   <= 1'b0;
          ovf   <= 1'b0;
          state <= LOAD_HI;
        end
        LOAD_HI:  begin hi_r <= in_bus; state <= LOAD_LO;  end
        LOAD_LO:  begin lo_r <= in_bus; state <= LOAD_DIV; end
        LOAD_DIV: begin dv_r <= in_bus; state <= CHECK;    end
        CHECK: begin
          // error results are settled here; they pass through CORR untouched
          if (dv_r == '0) begin
            dbz   <= 1'b1;
            err   <= 1'b1;
            q_r   <= '1;
            r_r   <= lo_r;
            state <= CORR;
          end else if (is_ovf) begin
            ovf   <= 1'b1;
            err   <= 1'b1;
            q_r   <= '1;
            r_r   <= '0;
            state <= CORR;
          end else begin
            err   <= 1'b0;
            rem_r <= {1'b0, dd_mag[2*W-1:W]};
            lo_r  <= dd_mag[W-1:0];
            dv_r  <= dv_mag;
            cnt   <= '0;
`ifdef NON_RES_DIV_SIGNED_EN
            sd_r  <= hi_r[W-1];
            sv_r  <= dv_r[W-1];
`endif
            state <= ITER;
          end
        end
        ITER: begin
          rem_r <= nrem;
          lo_r  <= {lo_r[W-2:0], ~nrem[W]};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(W-1)) state <= CORR;
        end
        CORR: begin
          if (!err) begin
`ifdef NON_RES_DIV_SIGNED_EN
            q_r <= (sd_r ^ sv_r) ? -lo_r : lo_r;
            r_r <= sd_r ? -rfin[W-1:0] : rfin[W-1:0];
`else
            q_r <= lo_r;
            r_r <= rfin[W-1:0];
`endif
          end
          state <= OUT_Q;
        end
        OUT_Q:   state <= OUT_R;
        OUT_R:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_bus = '0;
    fin     = 1'b0;
    if (state == OUT_Q) begin
      out_bus = q_r;
      fin     = 1'b1;
    end else if (state == OUT_R) begin
      out_bus = r_r;
      fin     = 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_non_res_div_param.sv
// Bench for non_res_div_param: directed table, multi-cycle corner sequences, random vs arithmetic model.
module tb_non_res_div_param;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, begin_div;
  logic [W-1:0] in_bus, out_bus;
  logic         fin, busy, dbz, ovf;
  int           checks = 0, errors = 0;

  non_res_div_param #(.W(W)) dut (
    .clk(clk), .rst(rst), .begin_div(begin_div), .in_bus(in_bus),
    .out_bus(out_bus), .fin(fin), .busy(busy), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] dd;
    logic [W-1:0]   dv;
    logic [W-1:0]   q, r;
    logic           ez, eo;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division of the whole operands.
  function automatic void model(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic ez, output logic eo);
    longint a, b, qm, rm;
    bit     nq, nr;
    ez = 1'b0; eo = 1'b0; q = '1; r = '0;
    if (dv == '0) begin
      ez = 1'b1; r = dd[W-1:0];
      return;
    end
`ifdef NON_RES_DIV_SIGNED_EN
    a = longint'($signed(dd));
    b = longint'($signed(dv));
    nq = (a < 0) != (b < 0);
    nr = a < 0;
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    if (a >= (b << (W-1))) begin eo = 1'b1; return; end
`else
    a = longint'(dd);
    b = longint'(dv);
    nq = 1'b0; nr = 1'b0;
    if (a >= (b << W)) begin eo = 1'b1; return; end
`endif
    qm = a / b;
    rm = a % b;
    q = W'(nq ? -qm : qm);
    r = W'(nr ? -rm : rm);
  endfunction

  // Entered and left at #1 after a rising edge with the DUT idle.
  task automatic do_op(input string nm, input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                       input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic ez, input logic eo, input bit hold);
    int k;
    int lat;
    lat = (ez || eo) ? 5 : W + 5;
    begin_div = 1'b1;
    in_bus    = dd[2*W-1:W];
    @(posedge clk); #1;                 // edge N
    if (!hold) begin_div = 1'b0;
    @(posedge clk); #1;
    in_bus = dd[W-1:0];
    @(posedge clk); #1;
    in_bus = dv;
    @(posedge clk); #1;
    in_bus = $urandom;
    chk({nm, "_quiet"}, {busy, fin, out_bus}, {1'b1, 1'b0, {W{1'b0}}});
    k = 3;
    while (!fin && k < W + 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_lat"}, k, lat);
    chk({nm, "_q"}, {fin, dbz, ovf, out_bus}, {1'b1, ez, eo, q});
    @(posedge clk); #1;
    chk({nm, "_r"}, {fin, dbz, ovf, out_bus}, {1'b1, ez, eo, r});
    @(posedge clk); #1;
    chk({nm, "_end"}, {fin, busy, out_bus}, {1'b0, 1'b0, {W{1'b0}}});
  endtask

  initial begin
    logic [2*W-1:0] dd;
    logic [W-1:0]   dv, q, r;
    logic           ez, eo;

`ifdef NON_RES_DIV_SIGNED_EN
    tbl[0] = '{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
    tbl[1] = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0};
    tbl[2] = '{16'h4000, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};
    tbl[4] = '{16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
`else
    tbl[0] = '{16'h1FA9, 8'h4F, 8'h66, 8'h2F, 1'b0, 1'b0};
    tbl[1] = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0};
    tbl[2] = '{16'h5000, 8'h40, 8'hFF, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{16'h00FF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0};
`endif

    rst = 1'b1; begin_div = 1'b0; in_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {out_bus, fin, busy, dbz, ovf}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i])
      do_op($sformatf("tbl%0d", i), tbl[i].dd, tbl[i].dv, tbl[i].q, tbl[i].r,
            tbl[i].ez, tbl[i].eo, 1'b0);

    // start held through a whole run: next accept only on the first idle edge
    do_op("hold1", tbl[0].dd, tbl[0].dv, tbl[0].q, tbl[0].r, tbl[0].ez, tbl[0].eo, 1'b1);
    do_op("hold2", tbl[3].dd, tbl[3].dv, tbl[3].q, tbl[3].r, tbl[3].ez, tbl[3].eo, 1'b0);

    // reset in the third ITER cycle
    begin_div = 1'b1; in_bus = tbl[0].dd[2*W-1:W];
    @(posedge clk); #1;
    begin_div = 1'b0;
    @(posedge clk); #1; in_bus = tbl[0].dd[W-1:0];
    @(posedge clk); #1; in_bus = tbl[0].dv;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_iter_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst", {out_bus, fin, busy, dbz, ovf}, '0);
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_held", {out_bus, fin, busy}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op("post_rst", tbl[0].dd, tbl[0].dv, tbl[0].q, tbl[0].r, tbl[0].ez, tbl[0].eo, 1'b0);

    for (int n = 0; n < 40; n++) begin
      dd = (2*W)'($urandom) >> $urandom_range(0, 2*W-1);
      if ($urandom_range(0, 3) == 0) dd = -dd;
      dv = W'($urandom) >> $urandom_range(0, W-1);
      if ($urandom_range(0, 1) == 1) dv = -dv;
      model(dd, dv, q, r, ez, eo);
      do_op($sformatf("rnd%0d", n), dd, dv, q, r, ez, eo, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/non_res_div_param.md
NON_RES_DIV_PARAM -- requirements
Module: non_res_div_param

Interface
REQ-001 SHALL have parameter W, default 8, meaning the width of the bus, divisor, quotient and remainder; the dividend is 2W bits; legal range 4..32.
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port begin_div  input  1  start strobe, sampled only in IDLE.
REQ-005 SHALL have port in_bus  input  W  operand bus: dividend high word, then dividend low word, then divisor.
REQ-006 SHALL have port out_bus  output  W  result bus: quotient, then remainder; 0 outside output states.
REQ-007 SHALL have port fin  output  1  high exactly in the two result cycles.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port dbz  output  1  divide-by-zero flag, valid while fin=1.
REQ-010 SHALL have port ovf  output  1  quotient-overflow flag, valid while fin=1.

Function
REQ-011 SHALL implement the FSM IDLE -> LOAD_HI -> LOAD_LO -> LOAD_DIV -> CHECK -> ITER (W cycles) -> CORR -> OUT_Q -> OUT_R -> IDLE.
REQ-012 SHALL register in_bus as dividend[2W-1:W] in LOAD_HI, dividend[W-1:0] in LOAD_LO and divisor in LOAD_DIV, one word per edge.
REQ-013 SHALL, in CHECK, set dbz and go to OUT_Q with quotient all-ones and remainder = dividend low word when divisor=0.
REQ-014 SHALL, in CHECK, set ovf and go to OUT_Q with quotient all-ones and remainder 0 when divisor!=0 and dividend high word >= divisor (unsigned mode).
REQ-015 SHALL perform one non-restoring step per ITER cycle on a W+1-bit signed partial remainder: shift left by one, then subtract the divisor if the remainder is >=0 or add it if <0; the quotient bit is the inverted new sign.
REQ-016 SHALL, in CORR, add the divisor to a negative final remainder; the quotient needs no correction.
REQ-017 SHALL drive quotient on out_bus in OUT_Q and remainder in OUT_R, with fin=1 in both.
REQ-018 SHALL give normal-path latency: begin_div sampled at edge N -> quotient on out_bus after edge N+W+5, remainder after edge N+W+6, IDLE after edge N+W+7.
REQ-019 SHALL give error-path latency (dbz/ovf): quotient after edge N+5, remainder after edge N+6.
REQ-020 SHALL ignore begin_div while busy=1, including in OUT_Q and OUT_R; a start is accepted only on the first IDLE edge.
REQ-021 SHALL clear dbz and ovf on acceptance of a new start and hold them stable from CHECK through OUT_R.
REQ-022 SHALL hold dbz=1 and ovf=0 when divisor=0, whatever the dividend.

Reset
REQ-023 SHALL, on rst=1 and without waiting for a clock edge, force state to IDLE and out_bus=0, fin=0, busy=0, dbz=0, ovf=0, and clear all operand and result registers.
REQ-024 SHALL abort any operation in progress on reset at any state, including mid-ITER, with no result emitted; the first start after rst deasserts SHALL behave normally.

Configuration
REQ-025 SHALL, when macro NON_RES_DIV_SIGNED_EN is defined, treat the dividend and divisor as two's complement: divide magnitudes in CHECK; in CORR set the quotient sign = dividend sign XOR divisor sign and the remainder sign = dividend sign.
REQ-026 SHALL, when NON_RES_DIV_SIGNED_EN is defined, set ovf if |dividend| >= |divisor|<<(W-1); latency SHALL be unchanged.
REQ-027 SHALL, when NON_RES_DIV_SIGNED_EN is undefined, treat all operands as unsigned and contain no sign logic.

Verification
REQ-028 SHALL cover: W=8, dividend 0x1FA9, divisor 0x4F -> out_bus 0x66 then 0x2F, fin for 2 cycles, dbz=ovf=0, quotient at edge N+13.
REQ-029 SHALL cover: divisor 0x00, dividend 0x1234 -> dbz=1, ovf=0, out_bus 0xFF then 0x34, quotient at edge N+5.
REQ-030 SHALL cover: dividend 0x5000, divisor 0x40 -> ovf=1, out_bus 0xFF then 0x00.
REQ-031 SHALL cover: rst pulsed in the 3rd ITER cycle -> all outputs 0 immediately; a fresh 0x1FA9/0x4F run then yields 0x66/0x2F.
REQ-032 SHALL cover: begin_div held high through a whole operation -> second start accepted only at the first IDLE edge, quotient at N'+13.
REQ-033 SHALL cover, with NON_RES_DIV_SIGNED_EN: dividend 0xFF9C (-100), divisor 0x07 -> out_bus 0xF2 (-14) then 0xFE (-2), ovf=0.
